// File: rtl/mul_share_pkg.sv
// Shared types, widths and helpers for the shared-multiplier controller.
package mul_share_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned MUL_W  = 33;
  localparam int unsigned PROD_W = 64;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // First operand is signed for every op except MULHU.
  function automatic logic [MUL_W-1:0] ext_a(input mul_op_e op, input logic [XLEN-1:0] a);
    return {(op != OP_MULHU) & a[XLEN-1], a};
  endfunction

  // Second operand is signed only for MUL/MULH.
  function automatic logic [MUL_W-1:0] ext_b(input mul_op_e op, input logic [XLEN-1:0] b);
    return {((op == OP_MUL) || (op == OP_MULH)) & b[XLEN-1], b};
  endfunction

  function automatic logic [XLEN-1:0] sel_half(input mul_op_e op, input logic [PROD_W-1:0] p);
    return (op == OP_MUL) ? p[XLEN-1:0] : p[PROD_W-1:XLEN];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the first requester at or after the pointer.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] gidx;
  logic          found;

  always_comb begin
    gnt   = '0;
    gidx  = ptr_q;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req[IW'((32'(ptr_q) + k) % N)]) begin
        found = 1'b1;
        gidx  = IW'((32'(ptr_q) + k) % N);
      end
    end
    if (found) gnt[gidx] = 1'b1;
  end

  // Pointer moves just past the granted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= IW'((32'(gidx) + 1) % N);
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one 33x33 signed multiplier between N_REQ requesters running RV32M ops.
// Define MUL_SHARE_CACHE_EN to enable the last-result cache.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ-1:0][1:0]      req_op,
  input  logic [N_REQ-1:0][XLEN-1:0] req_a,
  input  logic [N_REQ-1:0][XLEN-1:0] req_b,
  output logic [N_REQ-1:0]           resp_valid,
  input  logic [N_REQ-1:0]           resp_ready,
  output logic [XLEN-1:0]            resp_data,
  output logic                       m_req,
  output logic [MUL_W-1:0]           m_ai,
  output logic [MUL_W-1:0]           m_bi,
  input  logic                       m_rdy,
  input  logic [PROD_W-1:0]          m_r
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e          state_q, state_d;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]   sel_idx, owner_q;
  mul_op_e         sel_op, op_q;
  logic [XLEN-1:0] sel_a, sel_b, hit_data;
  logic [MUL_W-1:0] sel_ai, sel_bi;
  logic            accept, done, retire, hit;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .advance(accept),
    .gnt    (gnt)
  );

  // Granted requester's op and operands, already extended.
  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) sel_idx = IW'(i);
    end
    sel_op = mul_op_e'(req_op[sel_idx]);
    sel_a  = req_a[sel_idx];
    sel_b  = req_b[sel_idx];
    sel_ai = ext_a(sel_op, sel_a);
    sel_bi = ext_b(sel_op, sel_b);
  end

  assign req_ready = (rst_n && (state_q == S_IDLE)) ? gnt : '0;

`ifdef MUL_SHARE_CACHE_EN
  logic              c_vld;
  logic [MUL_W-1:0]  c_ai, c_bi;
  logic [PROD_W-1:0] c_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_vld <= 1'b0;
      c_ai  <= '0;
      c_bi  <= '0;
      c_r   <= '0;
    end else if (done) begin
      c_vld <= 1'b1;
      c_ai  <= m_ai;
      c_bi  <= m_bi;
      c_r   <= m_r;
    end
  end

  // The low half does not depend on signedness, so MUL only needs the raw operands.
  assign hit = c_vld && (((sel_ai == c_ai) && (sel_bi == c_bi)) ||
                         ((sel_op == OP_MUL) && (c_ai[XLEN-1:0] == sel_a) &&
                          (c_bi[XLEN-1:0] == sel_b)));
  assign hit_data = sel_half(sel_op, c_r);
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: if (|gnt) begin
        accept  = 1'b1;
        state_d = hit ? S_RESP : S_MUL;
      end
      S_MUL: if (m_rdy) begin
        done    = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: if (resp_ready[owner_q]) begin
        retire  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, multiplier handshake and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= '0;
      op_q       <= OP_MUL;
      m_req      <= 1'b0;
      m_ai       <= '0;
      m_bi       <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      if (accept) begin
        owner_q <= sel_idx;
        op_q    <= sel_op;
        if (hit) begin
          resp_valid <= N_REQ'(1) << sel_idx;
          resp_data  <= hit_data;
        end else begin
          m_req <= 1'b1;
          m_ai  <= sel_ai;
          m_bi  <= sel_bi;
        end
      end
      if (done) begin
        m_req      <= 1'b0;
        resp_valid <= N_REQ'(1) << owner_q;
        resp_data  <= sel_half(op_q, m_r);
      end
      if (retire) resp_valid <= '0;
    end
  end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl with a variable-latency multiplier model.
module tb_mul_share_ctrl;

  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0][1:0]  req_op;
  logic [NR-1:0][31:0] req_a;
  logic [NR-1:0][31:0] req_b;
  logic [NR-1:0]     resp_valid;
  logic [NR-1:0]     resp_ready;
  logic [31:0]       resp_data;
  logic              m_req;
  logic [32:0]       m_ai, m_bi;
  logic              m_rdy;
  logic [63:0]       m_r;

  mul_share_ctrl #(.N_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .m_req(m_req), .m_ai(m_ai), .m_bi(m_bi), .m_rdy(m_rdy), .m_r(m_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, data;
  } stim_t;

  typedef struct {
    int          owner;
    logic [31:0] data;
    logic [32:0] ai, bi;
    int          lat;
    int unsigned t_acc;
    bit          hit;
  } exp_t;

  stim_t pend[NR][$];
  exp_t  sb[$];

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int          hold = 0;
  int          ptr_m = 0;
  bit          seen = 0;
  int          waited = 0;
  logic [32:0] first_ai, first_bi, rdy_ai, rdy_bi;
  bit          prev_req = 0, prev_rdy = 0;
  int          mcnt;
`ifdef MUL_SHARE_CACHE_EN
  bit          cm_vld = 0;
  logic [32:0] cm_ai, cm_bi;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [32:0] tb_ext(input logic [31:0] v, input bit sgn);
    return {sgn & v[31], v};
  endfunction

  // Short products (both operands fit in 17 signed bits) finish in 3 cycles, others in 5.
  function automatic int mlat(input logic [32:0] ai, input logic [32:0] bi);
    bit sa, sb_;
    sa  = (&ai[32:16]) || !(|ai[32:16]);
    sb_ = (&bi[32:16]) || !(|bi[32:16]);
    return (sa && sb_) ? 3 : 5;
  endfunction

  function automatic logic [63:0] prod(input logic [32:0] ai, input logic [32:0] bi);
    logic signed [63:0] pa, pb;
    pa = 64'($signed(ai));
    pb = 64'($signed(bi));
    return pa * pb;
  endfunction

  // Multiplier model: m_rdy pulses after L cycles of m_req.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy <= 1'b0;
      m_r   <= '0;
      mcnt  <= 0;
    end else begin
      m_rdy <= 1'b0;
      if (m_req && !m_rdy) begin
        if (mcnt + 1 == mlat(m_ai, m_bi)) begin
          m_rdy <= 1'b1;
          m_r   <= prod(m_ai, m_bi);
          mcnt  <= 0;
        end else begin
          mcnt <= mcnt + 1;
        end
      end
    end
  end

  // Multiplier-port watcher: operand stability and m_req drop after m_rdy.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_req = 0;
      prev_rdy = 0;
    end else begin
      if (prev_rdy) check("m_req_low_after_rdy", m_req, 0);
      if (m_req && !prev_req) begin
        first_ai = m_ai;
        first_bi = m_bi;
      end
      if (m_rdy) begin
        rdy_ai = m_ai;
        rdy_bi = m_bi;
        check("m_ai_stable", m_ai, first_ai);
        check("m_bi_stable", m_bi, first_bi);
      end
      prev_req = m_req;
      prev_rdy = m_rdy;
    end
  end

  // Driver: presents queued requests and pushes expectations on accept.
  initial begin
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    forever begin
      @(negedge clk);
      for (int r = 0; r < NR; r++) begin
        if (rst_n && pend[r].size() > 0) begin
          req_valid[r] = 1'b1;
          req_op[r]    = pend[r][0].op;
          req_a[r]     = pend[r][0].a;
          req_b[r]     = pend[r][0].b;
        end else begin
          req_valid[r] = 1'b0;
        end
      end
      #1;
      if (rst_n && req_valid != '0) begin
        if (sb.size() != 0) begin
          check("no_accept_busy", req_ready, 0);
        end else begin
          int    g;
          stim_t s;
          exp_t  e;
          bit    sa, sbs;
          g = req_valid[ptr_m] ? ptr_m : (ptr_m + 1) % NR;
          check("grant", req_ready, 64'(1) << g);
          s = pend[g].pop_front();
          sa  = (s.op != 2'd3);
          sbs = (s.op == 2'd0) || (s.op == 2'd1);
          e.owner = g;
          e.data  = s.data;
          e.ai    = tb_ext(s.a, sa);
          e.bi    = tb_ext(s.b, sbs);
          e.lat   = mlat(e.ai, e.bi);
          e.t_acc = cyc;
          e.hit   = 0;
`ifdef MUL_SHARE_CACHE_EN
          e.hit = cm_vld && (((e.ai == cm_ai) && (e.bi == cm_bi)) ||
                             ((s.op == 2'd0) && (cm_ai[31:0] == s.a) && (cm_bi[31:0] == s.b)));
          if (!e.hit) begin
            cm_vld = 1;
            cm_ai  = e.ai;
            cm_bi  = e.bi;
          end
`endif
          sb.push_back(e);
          ptr_m = (g + 1) % NR;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a response is presented.
  initial begin
    resp_ready = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        resp_ready = '0;
      end else if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", resp_valid, 0);
        end else begin
          exp_t e;
          e = sb[0];
          if (!seen) begin
            seen   = 1;
            waited = 0;
            check("resp_owner", resp_valid, 64'(1) << e.owner);
            check("resp_data", resp_data, e.data);
            check("resp_latency", cyc - e.t_acc, e.hit ? 1 : 2 + e.lat);
            if (e.hit) begin
              check("hit_no_m_req", m_req, 0);
            end else begin
              check("m_ai_ext", rdy_ai, e.ai);
              check("m_bi_ext", rdy_bi, e.bi);
            end
          end else begin
            check("resp_hold_valid", resp_valid, 64'(1) << e.owner);
            check("resp_hold_data", resp_data, e.data);
          end
          if (waited < hold) begin
            resp_ready = '0;
            waited++;
          end else begin
            resp_ready = NR'(1) << e.owner;
            @(posedge clk);
            void'(sb.pop_front());
            seen = 0;
            #1 resp_ready = '0;
          end
        end
      end else begin
        resp_ready = '0;
      end
    end
  end

  task automatic push(input int r, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] d);
    stim_t s;
    s.op = op; s.a = a; s.b = b; s.data = d;
    pend[r].push_back(s);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((pend[0].size() + pend[1].size() + sb.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL wait_idle timeout after %0d cycles, pending=%0d", budget, sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_data"}, resp_data, 0);
    check({tag, "_m_req"}, m_req, 0);
    check({tag, "_m_ai"}, m_ai, 0);
    check({tag, "_m_bi"}, m_bi, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single-requester ops: short and full latency, all signedness variants.
    push(0, 2'd0, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFA);
    wait_idle(100);
    push(0, 2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    wait_idle(100);
    push(0, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    push(0, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(100);

    // Both requesters always valid: grants must alternate.
    push(0, 2'd0, 32'd5, 32'd7, 32'h0000_0023);
    push(0, 2'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
    push(0, 2'd0, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FF9C);
    push(0, 2'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    push(1, 2'd0, 32'd6, 32'd9, 32'h0000_0036);
    push(1, 2'd1, 32'h4000_0000, 32'd4, 32'h0000_0001);
    push(1, 2'd3, 32'h8000_0000, 32'd2, 32'h0000_0001);
    push(1, 2'd2, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
    wait_idle(400);

    // Back-pressure: response held while the other requester waits.
    hold = 4;
    push(0, 2'd0, 32'h11, 32'h3, 32'h0000_0033);
    push(1, 2'd3, 32'h0002_0000, 32'h0003_0000, 32'h0000_0006);
    wait_idle(200);
    hold = 0;

`ifdef MUL_SHARE_CACHE_EN
    // MULH then MUL/MULHU of the same operands are served from the cache.
    push(0, 2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
    wait_idle(100);
    push(0, 2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    wait_idle(100);
    push(1, 2'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
    wait_idle(100);
`endif

    // Asynchronous reset in the middle of a multiply.
    push(0, 2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);
    n = 0;
    while (!m_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("m_req_before_reset", m_req, 1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    pend[0].delete();
    pend[1].delete();
    sb.delete();
    seen = 0;
    ptr_m = 0;
`ifdef MUL_SHARE_CACHE_EN
    cm_vld = 0;
`endif
    #1 check_reset_outputs("midop_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("no_resp_after_reset", resp_valid, 0);

    // Lone requester 1 is granted with the pointer back at 0.
    push(1, 2'd3, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
    wait_idle(100);
    push(0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_idle(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_share_ctrl.md
# mul_share_ctrl

Shares the signed 33×33→64 multiplier between `N_REQ` requesters, such as core execute stages or accelerators. Each request carries an RV32M multiply op. The block arbitrates round-robin, sign- or zero-extends the operands to 33 bits, sequences the multiplier's req/rdy handshake, and returns the selected 32-bit half of the product. An optional last-result cache serves repeated operand pairs, e.g. MULH followed by MUL, without a multiply.

## Interface
- `N_REQ`, 2: number of requesters, ≥2.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  request present, per requester.
- `req_ready`  out  N_REQ  request accepted this cycle.
- `req_op`  in  N_REQ×2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- `req_a`, `req_b`  in  N_REQ×32  operands.
- `resp_valid`  out  N_REQ  result valid; held until `resp_ready`.
- `resp_ready`  in  N_REQ  result consumed.
- `resp_data`  out  32  result for the requester flagged by `resp_valid`.
- `m_req`  out  1  multiplier request.
- `m_ai`, `m_bi`  out  33  signed multiplier operands.
- `m_rdy`  in  1  multiplier done; one-cycle pulse.
- `m_r`  in  64  product; valid while `m_rdy`=1.

## Operation
- FSM states:
  - IDLE: grant via round-robin, accept one request.
  - MUL: `m_req` high until `m_rdy`.
  - RESP: `resp_valid` high until `resp_ready`.
- Transitions:
  - IDLE→MUL on accept.
  - IDLE→RESP on accept with cache hit.
  - MUL→RESP on `m_rdy`.
  - RESP→IDLE on `resp_ready` of the owner.
- Arbitration:
  - Only in IDLE; `req_ready` is one-hot or zero, and zero in all other states.
  - Priority pointer starts at requester 0 after reset.
  - After a grant to requester i, the pointer moves to i+1 mod N_REQ.
  - A lone requester is always granted.
- Operand extension:
  - MUL/MULH: both operands sign-extended.
  - MULHSU: `m_ai` sign-extended, `m_bi` zero-extended.
  - MULHU: both zero-extended.
- Operand stability: operands, op and owner index are registered on accept. `m_ai`/`m_bi` stay constant from the first `m_req` cycle through the `m_rdy` cycle.
- Result select: MUL returns `m_r[31:0]`; all other ops return `m_r[63:32]`. The result is registered on `m_rdy`.
- `m_req` waveform: high continuously from MUL entry until the cycle `m_rdy`=1 inclusive, then low for at least one cycle.
- Multiplier latency is variable; the FSM never assumes a fixed latency.
- Reset values:
  - `req_ready`=0, `resp_valid`=0, `resp_data`=0.
  - `m_req`=0, `m_ai`=`m_bi`=0.
  - State IDLE, pointer 0, cache invalid.
- Reset mid-operation: the in-flight request is dropped with no response; the multiplier is reset by the same `rst_n`.
- `req_valid` deasserted without a grant is legal; no state is kept for it.

## Timing
- Accept at cycle T (`req_valid`&`req_ready`).
- `m_req` first high at T+1.
- `m_rdy` at T+1+L, with L=3 (short product) or L=5 (full).
- `resp_valid` from T+2+L.
- Earliest next accept: the cycle after the `resp_ready` handshake.
- Throughput: one op per L+3 cycles minimum.
- Cache hit: `resp_valid` at T+1; `m_req` stays low.

## Configuration
- `MUL_SHARE_CACHE_EN` defined:
  - Stores the last `m_ai`, `m_bi` and 64-bit `m_r`.
  - Hit condition: the new extended 33-bit operands equal the stored ones.
  - MUL hits on any stored signedness if `req_a`/`req_b` match, because the low half is signedness-independent.
  - The cache updates on each `m_rdy`.
- Not defined: no cache storage; every request goes to MUL.

## Structure
- Package `mul_share_pkg` holds:
  - `mul_op_e` (MUL/MULH/MULHSU/MULHU).
  - `state_e` (IDLE/MUL/RESP).
  - `MUL_W`=33 and `PROD_W`=64.
- Sub-module `rr_arbiter` (parameter N): inputs `req`, `advance`; output one-hot `gnt`; owns the pointer.
- The top holds the FSM, operand extension, result select and the cache.

## Test plan
- Requester 0 MUL a=3, b=0xFFFFFFFE → `resp_data`=0xFFFFFFFA; `m_rdy` 3 cycles after first `m_req`.
- MULH a=b=0x80000000 → 0x40000000; full latency, L=5.
- MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- Both requesters valid every cycle, 4 ops each → grants alternate 0,1,0,1…; each `resp_valid` reaches only its owner.
- `resp_ready` held low 4 cycles → `resp_valid`/`resp_data` stable, no new accept. With cache: MULH a=b=0x00010000 → 1, then MUL of the same operands → 0 at T+1 with no `m_req`.
- `rst_n` low during MUL → all outputs reach reset values asynchronously; no response; after release, a new request completes normally.
